// File: rtl/onchip_memory_burst_pkg.sv
// Shared types and helpers for the burst-capable on-chip memory.
package onchip_mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2
    } mem_state_t;

    // Ceiling log2, usable in parameter defaults.
    function automatic int clog2(input int unsigned value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Effective burst length: zero means one beat, oversize requests saturate.
    function automatic int unsigned burst_clamp(input int unsigned count,
                                                input int unsigned max_burst);
        if (count == 0) begin
            return 1;
        end
        if (count > max_burst) begin
            return max_burst;
        end
        return count;
    endfunction

endpackage

// File: rtl/onchip_memory_burst_if.sv
// Avalon-MM slave bus bundle for the on-chip memory.
interface onchip_memory_burst_if
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int BURST_W = clog2(16) + 1
);
    logic                  chipselect;
    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W/8-1:0]   byteenable;
    logic [BURST_W-1:0]    burstcount;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output chipselect, read, write, address, byteenable, burstcount, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, burstcount, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_burst_ram.sv
// Single-port byte-enabled RAM with registered read (old data on
// read-during-write). Contents are not touched by any reset; INIT_FILE is
// carried so the vendor flow can attach a power-up image.
module onchip_ram_sp_be #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 40000,
    parameter int    ADDR_W    = 16,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                clken,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [NB-1:0]     byte_we;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign byte_we[gi] = we & be[gi];
    end

    // Registered read plus per-byte write, both gated by the clock enable.
    always_ff @(posedge clk) begin
        if (clken) begin
            rdata_q <= mem[addr];
            for (int b = 0; b < NB; b++) begin
                if (byte_we[b]) begin
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/onchip_memory_burst.sv
// Avalon-MM burst slave over an inferred RAM: command FSM, beat address
// generator with DEPTH wrap, range check and read-valid pipeline.
module onchip_memory_burst
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 40000,
    parameter int    ADDR_W    = 16,
    parameter int    MAX_BURST = 16,
    parameter int    BURST_W   = clog2(MAX_BURST) + 1,
    parameter int    OUTREG    = 0,
    parameter string INIT_FILE = ""
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clken,
    input  logic reset_req,
    onchip_memory_burst_if.slave bus
);
    localparam int                VLD_DEPTH = 1 + OUTREG;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_t           state_q, state_d;
    logic [BURST_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [VLD_DEPTH-1:0] vld_q, vld_d;
    logic                 oor_q, oor_d;
    logic [DATA_W-1:0]    hold_q, hold_d;

    logic                 stall;
    logic [BURST_W-1:0]   len;
    logic [ADDR_W-1:0]    beat_addr;
    logic                 beat_wr, beat_rd, in_range;
    logic [DATA_W-1:0]    ram_rdata, stage_data, out_data;
    logic                 rd_valid;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    assign stall    = ~clken | reset_req;
    assign len      = BURST_W'(burst_clamp(32'(bus.burstcount), 32'(MAX_BURST)));
    assign in_range = 32'(beat_addr) < 32'(DEPTH);

    // Command FSM: picks this cycle's beat and advances the burst counter.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        beat_addr = addr_q;
        beat_wr   = 1'b0;
        beat_rd   = 1'b0;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    beat_addr = bus.address;
                    if (bus.chipselect && (bus.read || bus.write)) begin
                        // A write that collides with a read takes priority.
                        beat_wr = bus.write;
                        beat_rd = ~bus.write;
                        addr_d  = next_addr(bus.address);
                        cnt_d   = len - BURST_W'(1);
                        if (len > BURST_W'(1)) begin
                            state_d = bus.write ? WR_BURST : RD_BURST;
                        end
                    end
                end
                WR_BURST: begin
                    if (bus.chipselect && bus.write) begin
                        beat_wr = 1'b1;
                        addr_d  = next_addr(addr_q);
                        cnt_d   = cnt_q - BURST_W'(1);
                        if (cnt_q == BURST_W'(1)) begin
                            state_d = IDLE;
                        end
                    end
                end
                RD_BURST: begin
                    beat_rd = 1'b1;
                    addr_d  = next_addr(addr_q);
                    cnt_d   = cnt_q - BURST_W'(1);
                    if (cnt_q == BURST_W'(1)) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read pipeline: valid shift register and out-of-range tag, frozen on stall.
    always_comb begin
        vld_d  = vld_q;
        oor_d  = oor_q;
        hold_d = hold_q;
        if (!stall) begin
            vld_d = (vld_q << 1) | VLD_DEPTH'(beat_rd);
            oor_d = ~in_range;
        end
        if (rd_valid) begin
            hold_d = out_data;
        end
    end

    // State register; RAM contents are deliberately outside the reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            vld_q   <= '0;
            oor_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            oor_q   <= oor_d;
            hold_q  <= hold_d;
        end
    end

    onchip_ram_sp_be #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .clken (~stall),
        .we    (beat_wr & in_range),
        .be    (bus.byteenable),
        .addr  (beat_addr),
        .wdata (bus.writedata),
        .rdata (ram_rdata)
    );

    assign stage_data = oor_q ? '0 : ram_rdata;

    if (OUTREG != 0) begin : g_outreg
        logic [DATA_W-1:0] data_q, data_d;
        // Optional output stage, advancing only on unstalled cycles.
        always_comb data_d = stall ? data_q : stage_data;
        // Output stage register.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end
        assign out_data = data_q;
    end else begin : g_no_outreg
        assign out_data = stage_data;
    end

    // A stalled cycle never shows a valid, so a held beat appears exactly once.
    assign rd_valid          = vld_q[VLD_DEPTH-1] & ~stall;
    assign bus.readdatavalid = rd_valid;
    assign bus.readdata      = rd_valid ? out_data : hold_q;
    assign bus.waitrequest   = stall | (state_q == RD_BURST);
endmodule

// File: tb/tb_onchip_memory_burst.sv
// Randomized scoreboard bench for onchip_memory_burst.
module tb_onchip_memory_burst;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 40000;
    localparam int ADDR_W    = 16;
    localparam int MAX_BURST = 16;
    localparam int BURST_W   = 5;
    localparam int OUTREG    = 1;
    localparam int L         = 1 + OUTREG;

    typedef struct {
        logic [31:0] data;
        bit          known;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clken = 1'b1;
    logic reset_req = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] last_rd = '0;
    logic [31:0] mem_m [int];
    exp_t exp_q [$];

    onchip_memory_burst_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    onchip_memory_burst #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST),
        .BURST_W(BURST_W), .OUTREG(OUTREG), .INIT_FILE("")
    ) dut (
        .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference rules: wrap at DEPTH, natural wrap of the address field otherwise.
    function automatic int nxt(input int a);
        return (a == DEPTH - 1) ? 0 : (a + 1) % (1 << ADDR_W);
    endfunction

    function automatic int blen(input int bc);
        if (bc == 0) return 1;
        if (bc > MAX_BURST) return MAX_BURST;
        return bc;
    endfunction

    function automatic void model_write(input int a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w;
        if (a >= DEPTH) return;
        if (!mem_m.exists(a)) begin
            if (be != 4'hF) return;
            w = '0;
        end else begin
            w = mem_m[a];
        end
        for (int b = 0; b < 4; b++) begin
            if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
        end
        mem_m[a] = w;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = ADDR_W'($urandom);
        bus.burstcount = BURST_W'($urandom);
    endtask

    task automatic write_burst(input int addr, input int bc, input logic [3:0] be,
                               input logic [31:0] d0, input int gap_at, input int gap_len,
                               input bit with_read);
        int a;
        int n;
        logic [31:0] d;
        a = addr;
        n = blen(bc);
        $display("[TB] WR addr=%0d burstcount=%0d beats=%0d be=%h gap_at=%0d gap_len=%0d rd=%0d",
                 addr, bc, n, be, gap_at, gap_len, with_read);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    bus.chipselect = 1'b1;
                    bus.write      = 1'b0;
                    bus.read       = 1'($urandom);
                    bus.address    = ADDR_W'($urandom);
                    bus.burstcount = BURST_W'($urandom);
                    next_cycle();
                end
            end
            d = (i == 0) ? d0 : $urandom;
            bus.chipselect = 1'b1;
            bus.write      = 1'b1;
            bus.read       = (i == 0) ? with_read : 1'($urandom);
            bus.address    = (i == 0) ? ADDR_W'(addr) : ADDR_W'($urandom);
            bus.burstcount = (i == 0) ? BURST_W'(bc) : BURST_W'($urandom);
            bus.byteenable = be;
            bus.writedata  = d;
            @(negedge clk);
            check("wr_waitrequest", 32'(bus.waitrequest), 32'd0);
            model_write(a, d, be);
            a = nxt(a);
            next_cycle();
        end
        idle_bus();
    endtask

    task automatic read_burst(input int addr, input int bc, input bit timed);
        int a;
        int n;
        exp_t e;
        a = addr;
        n = blen(bc);
        $display("[TB] RD addr=%0d burstcount=%0d beats=%0d timed=%0d", addr, bc, n, timed);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.address    = ADDR_W'(addr);
        bus.burstcount = BURST_W'(bc);
        bus.byteenable = 4'($urandom);
        bus.writedata  = $urandom;
        for (int i = 0; i < n; i++) begin
            e.known = (a >= DEPTH) || mem_m.exists(a);
            e.data  = 32'd0;
            if (a < DEPTH && mem_m.exists(a)) e.data = mem_m[a];
            e.due   = timed ? cyc + L + i : -1;
            exp_q.push_back(e);
            a = nxt(a);
        end
        @(negedge clk);
        check("rd_accept_waitrequest", 32'(bus.waitrequest), 32'd0);
        next_cycle();
        idle_bus();
    endtask

    task automatic wait_ready(input int exp_hi);
        int hi;
        bit done;
        hi = 0;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (bus.waitrequest === 1'b0) done = 1'b1;
            else hi++;
        end
        check("rd_waitrequest_cycles", 32'(hi), 32'(exp_hi));
        @(posedge clk);
        #1;
    endtask

    task automatic stall_wait();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            clken     = ($urandom % 3) != 0;
            reset_req = ($urandom % 5) == 0;
            @(negedge clk);
            if (clken && !reset_req) begin
                if (bus.waitrequest === 1'b0) done = 1'b1;
            end else begin
                check("stall_waitrequest", 32'(bus.waitrequest), 32'd1);
            end
            @(posedge clk);
            #1;
        end
        clken     = 1'b1;
        reset_req = 1'b0;
        check("stall_burst_done", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) next_cycle();
        check("drain_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor: every valid pops one expected beat, idle cycles must hold data.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset_n) begin
            last_rd = '0;
        end else if (bus.readdatavalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: readdatavalid=1 readdata=%h, expected no beat (cycle %0d)",
                         bus.readdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.known) check("readdata", bus.readdata, e.data);
                if (e.due >= 0) check("valid_cycle", 32'(cyc), 32'(e.due));
            end
            last_rd = bus.readdata;
        end else begin
            check("readdata_hold", bus.readdata, last_rd);
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int a;
        int bc;
        int n;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.burstcount = '0;
        bus.byteenable = '0;
        bus.writedata  = '0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_readdata", bus.readdata, 32'd0);
        check("reset_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        check("reset_waitrequest", 32'(bus.waitrequest), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();

        // Single write and readback.
        write_burst(5, 1, 4'hF, 32'hDEADBEEF, 99, 0, 1'b0);
        read_burst(5, 1, 1'b1);
        wait_ready(0);
        drain();

        // Byte enables.
        write_burst(7, 1, 4'hF, 32'h11223344, 99, 0, 1'b0);
        write_burst(7, 1, 4'h5, 32'hAABBCCDD, 99, 0, 1'b0);
        read_burst(7, 1, 1'b1);
        wait_ready(0);
        drain();

        // Fill the window used by the wrap and random tests.
        write_burst(39990, 16, 4'hF, $urandom, 99, 0, 1'b0);
        write_burst(6, 16, 4'hF, $urandom, 99, 0, 1'b0);

        // Burst read across the DEPTH wrap.
        read_burst(39998, 4, 1'b1);
        wait_ready(3);
        drain();

        // Burst write with idle gaps, then readback.
        write_burst(100, 3, 4'hF, 32'hCAFE0100, 1, 2, 1'b0);
        read_burst(100, 3, 1'b1);
        wait_ready(2);
        read_burst(100, 1, 1'b1);
        wait_ready(0);
        drain();

        // Back-to-back single reads.
        read_burst(5, 1, 1'b1);
        read_burst(7, 1, 1'b1);
        read_burst(101, 1, 1'b1);
        read_burst(102, 1, 1'b1);
        drain();

        // Stalls during an 8-beat read.
        write_burst(300, 8, 4'hF, $urandom, 99, 0, 1'b0);
        read_burst(300, 8, 1'b0);
        stall_wait();
        drain();

        // Reset mid-burst.
        write_burst(200, 8, 4'hF, 32'h0BADCAFE, 99, 0, 1'b0);
        read_burst(200, 8, 1'b1);
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midreset_readdata", bus.readdata, 32'd0);
        check("midreset_readdatavalid", 32'(bus.readdatavalid), 32'd0);
        check("midreset_waitrequest", 32'(bus.waitrequest), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        read_burst(200, 8, 1'b1);
        wait_ready(7);
        drain();

        // Burst length edge cases, out-of-range access, read+write collision.
        read_burst(5, 0, 1'b1);
        wait_ready(0);
        read_burst(39990, 31, 1'b1);
        wait_ready(15);
        write_burst(50000, 1, 4'hF, 32'h12345678, 99, 0, 1'b0);
        read_burst(50000, 1, 1'b1);
        wait_ready(0);
        write_burst(9, 1, 4'hF, 32'h5A5A1234, 99, 0, 1'b1);
        read_burst(9, 1, 1'b1);
        wait_ready(0);
        drain();

        // Randomized traffic against the reference model.
        repeat (80) begin
            if ($urandom % 8 == 0) a = 50000 + int'($urandom % 100);
            else if ($urandom % 2 == 1) a = 39990 + int'($urandom % 10);
            else a = int'($urandom % 12);
            bc = int'($urandom % 21);
            n  = blen(bc);
            if ($urandom % 2 == 1) begin
                write_burst(a, bc, 4'($urandom), $urandom, 1 + int'($urandom % n),
                            int'($urandom % 3), 1'b0);
            end else begin
                read_burst(a, bc, 1'b1);
                wait_ready(n - 1);
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
